// File: rtl/trena_serial_ctrl.sv
// Measurement sequencer for a serial tape-measure: starts the sensor, latches
// its BCD result (or a timeout marker) and streams it as ASCII bytes followed
// by a terminator, optionally repeating at a fixed interval.
module trena_serial_ctrl #(
    parameter int         DIGITOS        = 3,
    parameter logic [7:0] CARACTERE_FIM  = 8'h23,
    parameter int         TIMEOUT_CICLOS = 2_000_000,
    parameter int         PERIODO_CICLOS = 25_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mensurar,
    input  logic                   modo_continuo,
    output logic                   medir,
    input  logic                   medida_pronto,
    input  logic [4*DIGITOS-1:0]   medida,
    output logic                   tx_partida,
    output logic [7:0]             tx_dados,
    input  logic                   tx_pronto,
    output logic [4*DIGITOS-1:0]   medida_reg,
    output logic                   pronto,
    output logic                   erro_timeout,
    output logic [3:0]             db_estado
);

    // One shared counter serves both wait states; it must hold the larger limit.
    localparam int CMAX = (TIMEOUT_CICLOS > PERIODO_CICLOS) ? TIMEOUT_CICLOS : PERIODO_CICLOS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(DIGITOS + 1);

    // Index value that selects the terminator byte.
    localparam logic [IW-1:0] ULTIMO      = IW'(DIGITOS);
    localparam logic [CW-1:0] FIM_TIMEOUT = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [CW-1:0] FIM_PERIODO = CW'(PERIODO_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        MEDE           = 4'h1,
        ESPERA_MEDIDA  = 4'h2,
        ARMAZENA       = 4'h3,
        TRANSMITE      = 4'h4,
        ESPERA_TX      = 4'h5,
        PROXIMO        = 4'h6,
        FINAL          = 4'h7,
        ESPERA_PERIODO = 4'h8,
        TIMEOUT        = 4'hE
    } estado_t;

    estado_t         estado;
    estado_t         proximo;
    logic            mensurar_reg;
    logic            borda;
    logic [CW-1:0]   contador;
    logic [IW-1:0]   indice;
    logic [3:0]      nibble;
    logic [7:0]      byte_atual;

    assign borda     = mensurar & ~mensurar_reg;
    assign db_estado = estado;

    // State register plus the datapath registers each state updates.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            estado       <= INICIAL;
            mensurar_reg <= 1'b0;
            contador     <= '0;
            indice       <= '0;
            medida_reg   <= '0;
            erro_timeout <= 1'b0;
        end else begin
            estado       <= proximo;
            mensurar_reg <= mensurar;

            // Counter restarts on every state change, so each wait starts at 0.
            if ((proximo != estado) ||
                !((estado == ESPERA_MEDIDA) || (estado == ESPERA_PERIODO)))
                contador <= '0;
            else
                contador <= contador + 1'b1;

            case (estado)
                ARMAZENA: begin
                    medida_reg   <= medida;
                    erro_timeout <= 1'b0;
                    indice       <= '0;
                end
                TIMEOUT: begin
                    medida_reg   <= '1;
                    erro_timeout <= 1'b1;
                    indice       <= '0;
                end
                PROXIMO: begin
                    if (indice != ULTIMO)
                        indice <= indice + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and the one-cycle strobes tied to specific states.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        proximo    = estado;
        medir      = 1'b0;
        tx_partida = 1'b0;
        pronto     = 1'b0;
        case (estado)
            INICIAL:        if (borda) proximo = MEDE;
            MEDE: begin
                medir   = 1'b1;
                proximo = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                if (medida_pronto)
                    proximo = ARMAZENA;
                else if (contador == FIM_TIMEOUT)
                    proximo = TIMEOUT;
            end
            ARMAZENA:       proximo = TRANSMITE;
            TIMEOUT:        proximo = TRANSMITE;
            TRANSMITE: begin
                tx_partida = 1'b1;
                proximo    = ESPERA_TX;
            end
            ESPERA_TX:      if (tx_pronto) proximo = PROXIMO;
            PROXIMO:        proximo = (indice == ULTIMO) ? FINAL : TRANSMITE;
            FINAL: begin
                pronto  = 1'b1;
                proximo = modo_continuo ? ESPERA_PERIODO : INICIAL;
            end
            ESPERA_PERIODO: begin
                if (!modo_continuo)
                    proximo = INICIAL;
                else if (contador == FIM_PERIODO)
                    proximo = MEDE;
            end
            default:        proximo = INICIAL;
        endcase
    end

    // Select the current digit (most significant first) and map it to ASCII.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (indice == IW'(DIGITOS - 1 - i))
                nibble = medida_reg[4*i +: 4];
        end

        if (indice == ULTIMO)
            byte_atual = CARACTERE_FIM;
        else if (nibble <= 4'd9)
            byte_atual = 8'h30 + {4'h0, nibble};
        else if ((nibble == 4'hF) && erro_timeout)
            byte_atual = 8'h2D;
        else
            byte_atual = 8'h3F;
    end

    // Byte is driven only while a transfer is being started or awaited; the
    // index cannot change in those states, so the value is stable throughout.
    always_comb begin
        tx_dados = 8'h00;
        if ((estado == TRANSMITE) || (estado == ESPERA_TX))
            tx_dados = byte_atual;
    end

endmodule

// File: tb/tb_trena_serial_ctrl.sv
// Directed bench for trena_serial_ctrl with DIGITOS=3, TIMEOUT_CICLOS=100 and
// PERIODO_CICLOS=50; the bench plays the sensor and the UART.
module tb_trena_serial_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        mensurar;
    logic        modo_continuo;
    logic        medir;
    logic        medida_pronto;
    logic [11:0] medida;
    logic        tx_partida;
    logic [7:0]  tx_dados;
    logic        tx_pronto;
    logic [11:0] medida_reg;
    logic        pronto;
    logic        erro_timeout;
    logic [3:0]  db_estado;

    int errors = 0;
    int checks = 0;
    int medir_count = 0;
    int pronto_count = 0;

    logic [7:0] rx_bytes [4];
    bit         rx_ok;
    bit         rx_stable;
    bit         toggle_in_tx = 1'b0;

    always #5 clock = ~clock;

    trena_serial_ctrl #(
        .DIGITOS        (3),
        .CARACTERE_FIM  (8'h23),
        .TIMEOUT_CICLOS (100),
        .PERIODO_CICLOS (50)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mensurar      (mensurar),
        .modo_continuo (modo_continuo),
        .medir         (medir),
        .medida_pronto (medida_pronto),
        .medida        (medida),
        .tx_partida    (tx_partida),
        .tx_dados      (tx_dados),
        .tx_pronto     (tx_pronto),
        .medida_reg    (medida_reg),
        .pronto        (pronto),
        .erro_timeout  (erro_timeout),
        .db_estado     (db_estado)
    );

    // Pulse counters sampled at the active edge (pre-update values).
    always @(posedge clock) begin
        if (medir === 1'b1) medir_count++;
        if (pronto === 1'b1) pronto_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Rising edge on mensurar; returns one cycle later (FSM should be in MEDE).
    task automatic pulse_mensurar();
        mensurar = 1'b1;
        tick();
        mensurar = 1'b0;
    endtask

    // Sensor answers after 'atraso' cycles; returns with the FSM in ARMAZENA.
    task automatic respond_sensor(input logic [11:0] v, input int atraso);
        medida = v;
        repeat (atraso) tick();
        medida_pronto = 1'b1;
        tick();
        medida_pronto = 1'b0;
    endtask

    // UART model: capture four bytes, hold each in flight for a few cycles.
    task automatic collect_bytes();
        int w;
        rx_ok = 1'b1;
        rx_stable = 1'b1;
        for (int k = 0; k < 4; k++) rx_bytes[k] = 8'hxx;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (tx_partida !== 1'b1 && w < 200) begin
                tick();
                w++;
            end
            if (w >= 200) begin
                rx_ok = 1'b0;
                return;
            end
            rx_bytes[k] = tx_dados;
            tick();
            if (tx_partida !== 1'b0) rx_stable = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (tx_dados !== rx_bytes[k] || db_estado !== 4'h5) rx_stable = 1'b0;
                if (toggle_in_tx) mensurar = ~mensurar;
                tick();
            end
            mensurar = 1'b0;
            if (tx_dados !== rx_bytes[k]) rx_stable = 1'b0;
            tx_pronto = 1'b1;
            tick();
            tx_pronto = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_estado: got %h want 0", db_estado); end
        checks++; if (medir !== 1'b0) begin errors++; $display("FAIL reset_medir: got %b want 0", medir); end
        checks++; if (tx_partida !== 1'b0) begin errors++; $display("FAIL reset_tx_partida: got %b want 0", tx_partida); end
        checks++; if (tx_dados !== 8'h00) begin errors++; $display("FAIL reset_tx_dados: got %h want 00", tx_dados); end
        checks++; if (medida_reg !== 12'h000) begin errors++; $display("FAIL reset_medida_reg: got %h want 000", medida_reg); end
        checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b want 0", pronto); end
        checks++; if (erro_timeout !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b want 0", erro_timeout); end
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (db_estado !== 4'h0 || medir !== 1'b0) begin errors++; $display("FAIL idle_after_reset: estado=%h medir=%b want 0/0", db_estado, medir); end
    endtask

    task automatic test_single_shot();
        int m0 = medir_count;
        int p0 = pronto_count;
        mensurar = 1'b1;
        checks++; if (medir !== 1'b0) begin errors++; $display("FAIL single_medir_edge_cycle: got %b want 0", medir); end
        tick();
        mensurar = 1'b0;
        checks++; if (medir !== 1'b1 || db_estado !== 4'h1) begin errors++; $display("FAIL single_medir_next: medir=%b estado=%h want 1/1", medir, db_estado); end
        respond_sensor(12'h025, 3);
        checks++; if (db_estado !== 4'h3) begin errors++; $display("FAIL single_armazena: got %h want 3", db_estado); end
        collect_bytes();
        checks++; if (!rx_ok) begin errors++; $display("FAIL single_tx_wait: got timeout want 4 bytes"); end
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h30323523) begin errors++;
            $display("FAIL single_bytes: got %h%h%h%h want 30323523", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        checks++; if (!rx_stable) begin errors++; $display("FAIL single_tx_stable: got unstable want stable"); end
        checks++; if (medida_reg !== 12'h025) begin errors++; $display("FAIL single_medida_reg: got %h want 025", medida_reg); end
        tick();
        checks++; if (pronto !== 1'b1 || db_estado !== 4'h7) begin errors++; $display("FAIL single_pronto: pronto=%b estado=%h want 1/7", pronto, db_estado); end
        tick();
        checks++; if (pronto !== 1'b0 || db_estado !== 4'h0) begin errors++; $display("FAIL single_return: pronto=%b estado=%h want 0/0", pronto, db_estado); end
        checks++; if (medir_count - m0 != 1 || pronto_count - p0 != 1) begin errors++;
            $display("FAIL single_pulse_counts: medir=%0d pronto=%0d want 1/1", medir_count - m0, pronto_count - p0); end
    endtask

    task automatic test_timeout();
        int dwell = 0;
        pulse_mensurar();
        tick();
        while (db_estado === 4'h2 && dwell < 300) begin
            dwell++;
            tick();
        end
        checks++; if (dwell != 100 || db_estado !== 4'hE) begin errors++; $display("FAIL timeout_dwell: cycles=%0d estado=%h want 100/e", dwell, db_estado); end
        collect_bytes();
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h2D2D2D23) begin errors++;
            $display("FAIL timeout_bytes: got %h%h%h%h want 2d2d2d23", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        checks++; if (erro_timeout !== 1'b1 || medida_reg !== 12'hFFF) begin errors++; $display("FAIL timeout_flag: erro=%b reg=%h want 1/fff", erro_timeout, medida_reg); end
        repeat (2) tick();
        checks++; if (db_estado !== 4'h0 || erro_timeout !== 1'b1) begin errors++; $display("FAIL timeout_return: estado=%h erro=%b want 0/1", db_estado, erro_timeout); end
        pulse_mensurar();
        respond_sensor(12'h789, 2);
        collect_bytes();
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h37383923) begin errors++;
            $display("FAIL recover_bytes: got %h%h%h%h want 37383923", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        checks++; if (erro_timeout !== 1'b0) begin errors++; $display("FAIL recover_erro_clear: got %b want 0", erro_timeout); end
        repeat (2) tick();
    endtask

    task automatic test_continuous();
        int dwell = 0;
        int m0;
        modo_continuo = 1'b1;
        pulse_mensurar();
        respond_sensor(12'h100, 2);
        collect_bytes();
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h31303023) begin errors++;
            $display("FAIL cont_bytes1: got %h%h%h%h want 31303023", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        tick();
        checks++; if (pronto !== 1'b1) begin errors++; $display("FAIL cont_pronto1: got %b want 1", pronto); end
        tick();
        while (db_estado === 4'h8 && dwell < 300) begin
            dwell++;
            tick();
        end
        checks++; if (dwell != 50 || db_estado !== 4'h1 || medir !== 1'b1) begin errors++;
            $display("FAIL cont_period: cycles=%0d estado=%h medir=%b want 50/1/1", dwell, db_estado, medir); end
        respond_sensor(12'h200, 2);
        collect_bytes();
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h32303023) begin errors++;
            $display("FAIL cont_bytes2: got %h%h%h%h want 32303023", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        repeat (2) tick();
        repeat (10) tick();
        checks++; if (db_estado !== 4'h8) begin errors++; $display("FAIL cont_waiting: got %h want 8", db_estado); end
        modo_continuo = 1'b0;
        m0 = medir_count;
        tick();
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL cont_stop: got %h want 0", db_estado); end
        repeat (80) tick();
        checks++; if (medir_count != m0 || db_estado !== 4'h0) begin errors++;
            $display("FAIL cont_no_more_medir: extra=%0d estado=%h want 0/0", medir_count - m0, db_estado); end
    endtask

    task automatic test_busy_invalid();
        int m0 = medir_count;
        pulse_mensurar();
        respond_sensor(12'h1A3, 2);
        toggle_in_tx = 1'b1;
        collect_bytes();
        toggle_in_tx = 1'b0;
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h313F3323) begin errors++;
            $display("FAIL invalid_bytes: got %h%h%h%h want 313f3323", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        repeat (12) tick();
        checks++; if (medir_count - m0 != 1 || db_estado !== 4'h0) begin errors++;
            $display("FAIL busy_no_queue: medir=%0d estado=%h want 1/0", medir_count - m0, db_estado); end
        pulse_mensurar();
        respond_sensor(12'h9F0, 2);
        collect_bytes();
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h393F3023) begin errors++;
            $display("FAIL f_without_erro: got %h%h%h%h want 393f3023", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_tx();
        pulse_mensurar();
        respond_sensor(12'h456, 2);
        tick();
        checks++; if (tx_partida !== 1'b1 || tx_dados !== 8'h34) begin errors++; $display("FAIL mid_byte0: partida=%b dados=%h want 1/34", tx_partida, tx_dados); end
        tick();
        tx_pronto = 1'b1;
        tick();
        tx_pronto = 1'b0;
        tick();
        checks++; if (tx_partida !== 1'b1 || tx_dados !== 8'h35) begin errors++; $display("FAIL mid_byte1: partida=%b dados=%h want 1/35", tx_partida, tx_dados); end
        tick();
        checks++; if (db_estado !== 4'h5) begin errors++; $display("FAIL mid_in_tx: got %h want 5", db_estado); end
        reset = 1'b1;
        tick();
        checks++; if (db_estado !== 4'h0 || tx_dados !== 8'h00 || medida_reg !== 12'h000 || erro_timeout !== 1'b0 ||
                      medir !== 1'b0 || tx_partida !== 1'b0 || pronto !== 1'b0) begin errors++;
            $display("FAIL mid_reset_outputs: estado=%h dados=%h reg=%h erro=%b medir=%b partida=%b pronto=%b want all 0",
                     db_estado, tx_dados, medida_reg, erro_timeout, medir, tx_partida, pronto); end
        reset = 1'b0;
        tick();
        pulse_mensurar();
        checks++; if (medir !== 1'b1) begin errors++; $display("FAIL after_reset_medir: got %b want 1", medir); end
        respond_sensor(12'h387, 2);
        collect_bytes();
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h33383723) begin errors++;
            $display("FAIL after_reset_bytes: got %h%h%h%h want 33383723", rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        checks++; if (medida_reg !== 12'h387) begin errors++; $display("FAIL after_reset_reg: got %h want 387", medida_reg); end
        tick();
        checks++; if (pronto !== 1'b1) begin errors++; $display("FAIL after_reset_pronto: got %b want 1", pronto); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        mensurar = 1'b0;
        modo_continuo = 1'b0;
        medida_pronto = 1'b0;
        medida = 12'h000;
        tx_pronto = 1'b0;
        test_reset();
        test_single_shot();
        test_timeout();
        test_continuous();
        test_busy_invalid();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trena_serial_ctrl.md
TRENA_SERIAL_CTRL -- requirements
Module: trena_serial_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITOS, default 3, giving the number of BCD digits per measurement (1..6).
REQ-002 The block SHALL have parameter CARACTERE_FIM, default 8'h23 ('#'), giving the terminator byte sent after the digits.
REQ-003 The block SHALL have parameter TIMEOUT_CICLOS, default 2_000_000, giving the maximum wait for medida_pronto after medir.
REQ-004 The block SHALL have parameter PERIODO_CICLOS, default 25_000_000, giving the continuous-mode interval.
REQ-005 The block SHALL have port clock, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-007 The block SHALL have port mensurar, input, 1 bit, a level request whose rising edge is detected internally.
REQ-008 The block SHALL have port modo_continuo, input, 1 bit, which enables periodic re-measurement.
REQ-009 The block SHALL have port medir, output, 1 bit, a one-cycle start pulse to the sensor interface.
REQ-010 The block SHALL have port medida_pronto, input, 1 bit, a one-cycle pulse from the sensor interface.
REQ-011 The block SHALL have port medida, input, 4*DIGITOS bits, the BCD result, most significant digit in the top nibble.
REQ-012 The block SHALL have port tx_partida, output, 1 bit, a one-cycle byte-start pulse to the UART transmitter.
REQ-013 The block SHALL have port tx_dados, output, 8 bits, the byte to transmit.
REQ-014 The block SHALL have port tx_pronto, input, 1 bit, a one-cycle pulse from the UART marking byte completion.
REQ-015 The block SHALL have port medida_reg, output, 4*DIGITOS bits, the last latched result.
REQ-016 The block SHALL have port pronto, output, 1 bit, a one-cycle pulse marking end of a measure+transmit cycle.
REQ-017 The block SHALL have port erro_timeout, output, 1 bit, which is set when the last measurement timed out.
REQ-018 The block SHALL have port db_estado, output, 4 bits, the current FSM state code.

Function
REQ-019 The FSM SHALL have these states and codes: INICIAL=0, MEDE=1, ESPERA_MEDIDA=2, ARMAZENA=3, TRANSMITE=4, ESPERA_TX=5, PROXIMO=6, FINAL=7, ESPERA_PERIODO=8, TIMEOUT=E.
REQ-020 The block SHALL register mensurar once, and SHALL define edge = mensurar AND NOT registered mensurar.
REQ-021 INICIAL SHALL go to MEDE on edge, and medir SHALL be high exactly in the cycle after the edge cycle.
REQ-022 The block SHALL assert medir only in state MEDE, and MEDE SHALL always go to ESPERA_MEDIDA.
REQ-023 ESPERA_MEDIDA SHALL go to ARMAZENA on medida_pronto, and to TIMEOUT when its counter reaches TIMEOUT_CICLOS-1 without medida_pronto; medida_pronto in the same cycle wins.
REQ-024 ARMAZENA SHALL latch medida into medida_reg, clear erro_timeout, zero the digit index, and go to TRANSMITE.
REQ-025 TIMEOUT SHALL load medida_reg with all 4'hF, set erro_timeout, zero the digit index, and go to TRANSMITE.
REQ-026 Byte order SHALL be digit DIGITOS-1 down to digit 0, then CARACTERE_FIM, giving DIGITOS+1 bytes per cycle.
REQ-027 Digit-to-byte mapping SHALL be: nibble 0..9 -> 8'h30+nibble; 4'hF with erro_timeout -> 8'h2D ('-'); any other nibble -> 8'h3F ('?').
REQ-028 In TRANSMITE, tx_partida SHALL be high for one cycle and the FSM SHALL then go to ESPERA_TX.
REQ-029 tx_dados SHALL be stable from TRANSMITE until tx_pronto is accepted.
REQ-030 ESPERA_TX SHALL wait indefinitely for tx_pronto, and SHALL ignore a tx_pronto coincident with tx_partida.
REQ-031 PROXIMO SHALL go to FINAL after the terminator byte, and otherwise SHALL increment the index and go to TRANSMITE.
REQ-032 FINAL SHALL assert pronto for one cycle, and SHALL then go to ESPERA_PERIODO if modo_continuo=1, otherwise to INICIAL.
REQ-033 ESPERA_PERIODO SHALL count from 0 on entry and go to MEDE at PERIODO_CICLOS-1, and SHALL go to INICIAL in any cycle where modo_continuo=0.
REQ-034 Edges on mensurar outside INICIAL SHALL be ignored, with no queuing.
REQ-035 Counters SHALL be wide enough for their parameters, and SHALL clear on every state entry that uses them.

Reset
REQ-036 With reset=1 at a clock edge, the next state SHALL be INICIAL; reset SHALL have priority over all other inputs, including mid-transmission.
REQ-037 On reset, outputs SHALL be: medir=0, tx_partida=0, tx_dados=8'h00, medida_reg=0, pronto=0, erro_timeout=0, db_estado=0; all counters and the index SHALL be 0, and registered mensurar SHALL be 0.

Verification
REQ-038 Single shot: with DIGITOS=3, mensurar rises and medida_pronto returns medida=12'h025 -> bytes 30,32,35,23, medida_reg=025, one pronto pulse, state back to 0.
REQ-039 Timeout: with TIMEOUT_CICLOS=100 and no medida_pronto -> TIMEOUT entered 100 cycles after medir, bytes 2D,2D,2D,23, erro_timeout=1; a later good measurement clears it.
REQ-040 Continuous mode: with PERIODO_CICLOS=50 and modo_continuo=1 -> medir repeats 50 cycles after each pronto; dropping modo_continuo during ESPERA_PERIODO returns to INICIAL with no further medir.
REQ-041 Busy and invalid data: mensurar toggles during ESPERA_TX -> no extra medir; medida=12'h1A3 -> bytes 31,3F,33,23.
REQ-042 Reset mid-operation: reset asserted in ESPERA_TX on the second byte -> next cycle db_estado=0 and all outputs at reset values; a new mensurar edge then yields a full, correct sequence.
